// File: rtl/apb_regbank_pkg.sv
// Shared types for the APB register bank: FSM states, error causes and the
// byte-lane merge used when committing writes.
package apb_regbank_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE,
      ERR_RANGE,
      ERR_ALIGN,
      ERR_RO,
      ERR_PRIV
   } err_e;

   localparam int MAX_DW    = 32;
   localparam int MAX_LANES = MAX_DW / 8;

   // Lanes with strb set take the new byte, all others keep the old one.
   function automatic logic [MAX_DW-1:0] lane_merge(
      input logic [MAX_DW-1:0]    old_word,
      input logic [MAX_DW-1:0]    new_word,
      input logic [MAX_LANES-1:0] strb
   );
      logic [MAX_DW-1:0] merged;
      merged = old_word;
      for (int b = 0; b < MAX_LANES; b++) begin
         if (strb[b]) begin
            merged[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: register index, hit flag and the first
// error cause found (range, alignment, read-only write, privilege).
module apb_addr_decode
   import apb_regbank_pkg::*;
#(
   parameter logic [31:0]       BASE_ADDR  = 32'd8,
   parameter int                DATA_WIDTH = 32,
   parameter int                N_REGS     = 8,
   parameter logic [N_REGS-1:0] RO_MASK    = 8'h80,
   parameter logic [N_REGS-1:0] PRIV_MASK  = 8'h40,
   parameter int                IDX_W      = 3
) (
   input  logic [31:0]      paddr,
   input  logic             pwrite,
   input  logic             priv,
   output logic [IDX_W-1:0] idx,
   output logic             hit,
   output err_e             cause
);

   localparam int          BYTES      = DATA_WIDTH / 8;
   localparam int          LSB        = $clog2(BYTES);
   localparam logic [32:0] END_ADDR   = {1'b0, BASE_ADDR} + 33'(N_REGS * BYTES);
   localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

   logic [31:0] offset;

   // Compared in 33 bits so a bank ending at the top of the map cannot wrap.
   always_comb begin
      offset = paddr - BASE_ADDR;
      idx    = IDX_W'(offset >> LSB);
      if ((paddr < BASE_ADDR) || ({1'b0, paddr} >= END_ADDR)) begin
         cause = ERR_RANGE;
      end else if ((paddr & ALIGN_MASK) != 32'd0) begin
         cause = ERR_ALIGN;
      end else if (pwrite && RO_MASK[idx]) begin
         cause = ERR_RO;
      end else if (!priv && PRIV_MASK[idx]) begin
         cause = ERR_PRIV;
      end else begin
         cause = ERR_NONE;
      end
      hit = (cause == ERR_NONE);
   end

endmodule

// File: rtl/apb_regbank_slave.sv
// APB4 completer with a parametrised register bank, programmable wait states,
// byte-lane writes, read-only status words, privileged registers and errors.
module apb_regbank_slave
   import apb_regbank_pkg::*;
#(
   parameter logic [31:0]       BASE_ADDR   = 32'd8,
   parameter int                DATA_WIDTH  = 32,
   parameter int                N_REGS      = 8,
   parameter int                WAIT_CYCLES = 2,
   parameter logic [N_REGS-1:0] RO_MASK     = 8'h80,
   parameter logic [N_REGS-1:0] PRIV_MASK   = 8'h40
) (
   input  logic                         pclk,
   input  logic                         presetn,
   input  logic [31:0]                  paddr,
   input  logic [2:0]                   pprot,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [DATA_WIDTH-1:0]        pwdata,
   input  logic [DATA_WIDTH/8-1:0]      pstrb,
   output logic                         pready,
   output logic [DATA_WIDTH-1:0]        prdata,
   output logic                         pslverr,
   input  logic [N_REGS*DATA_WIDTH-1:0] hw_status,
   output logic [N_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [N_REGS-1:0]            reg_wr
);

   localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

   state_e                  state_reg, state_next;
   logic [3:0]              cnt_reg, cnt_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic                    hit_reg, hit_next;
   err_e                    err_reg, err_next;
   logic                    write_reg, write_next;
   logic                    pready_reg, pready_next;
   logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
   logic                    pslverr_reg, pslverr_next;
   logic [N_REGS-1:0]       reg_wr_reg, reg_wr_next;
   logic                    commit;
   logic                    go_access;

   logic [IDX_W-1:0]        dec_idx;
   logic                    dec_hit;
   err_e                    dec_cause;

   logic [DATA_WIDTH-1:0]   regs_reg [N_REGS];
   logic [DATA_WIDTH-1:0]   rd_word  [N_REGS];
   logic [DATA_WIDTH-1:0]   wr_word;

   logic                    unused_prot;
   assign unused_prot = ^pprot[2:1];

   apb_addr_decode #(
      .BASE_ADDR  (BASE_ADDR),
      .DATA_WIDTH (DATA_WIDTH),
      .N_REGS     (N_REGS),
      .RO_MASK    (RO_MASK),
      .PRIV_MASK  (PRIV_MASK),
      .IDX_W      (IDX_W)
   ) u_decode (
      .paddr  (paddr),
      .pwrite (pwrite),
      .priv   (pprot[0]),
      .idx    (dec_idx),
      .hit    (dec_hit),
      .cause  (dec_cause)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_REGS; gi++) begin : g_slice
         assign rd_word[gi] = RO_MASK[gi] ? hw_status[gi*DATA_WIDTH +: DATA_WIDTH] : regs_reg[gi];
         assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[gi] ? '0 : regs_reg[gi];
      end
   endgenerate

   assign wr_word = DATA_WIDTH'(lane_merge(MAX_DW'(regs_reg[idx_reg]), MAX_DW'(pwdata),
                                           MAX_LANES'(pstrb)));

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      idx_next     = idx_reg;
      hit_next     = hit_reg;
      err_next     = err_reg;
      write_next   = write_reg;
      pready_next  = 1'b0;
      prdata_next  = '0;
      pslverr_next = 1'b0;
      reg_wr_next  = '0;
      commit       = 1'b0;
      go_access    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (psel && !penable) begin
               idx_next   = dec_idx;
               hit_next   = dec_hit;
               err_next   = dec_cause;
               write_next = pwrite;
               cnt_next   = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  go_access = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            // Losing psel or penable mid-wait abandons the transfer silently.
            if (!(psel && penable)) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg <= 4'd1) begin
               go_access = 1'b1;
               cnt_next  = '0;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ACCESS: begin
            state_next = IDLE;
            if (hit_reg && write_reg) begin
               commit               = 1'b1;
               reg_wr_next[idx_reg] = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Response is registered on entry to ACCESS so pready lands in that cycle.
      if (go_access) begin
         state_next   = ACCESS;
         pready_next  = 1'b1;
         pslverr_next = (err_next != ERR_NONE);
         if (hit_next && !write_next) begin
            prdata_next = rd_word[idx_next];
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         idx_reg     <= '0;
         hit_reg     <= 1'b0;
         err_reg     <= ERR_NONE;
         write_reg   <= 1'b0;
         pready_reg  <= 1'b0;
         prdata_reg  <= '0;
         pslverr_reg <= 1'b0;
         reg_wr_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         hit_reg     <= hit_next;
         err_reg     <= err_next;
         write_reg   <= write_next;
         pready_reg  <= pready_next;
         prdata_reg  <= prdata_next;
         pslverr_reg <= pslverr_next;
         reg_wr_reg  <= reg_wr_next;
      end
   end

   always_ff @(posedge pclk) begin
      for (int i = 0; i < N_REGS; i++) begin
         if (!presetn) begin
            regs_reg[i] <= '0;
         end else if (commit && (idx_reg == IDX_W'(i)) && !RO_MASK[i]) begin
            regs_reg[i] <= wr_word;
         end
      end
   end

   assign pready  = pready_reg;
   assign prdata  = prdata_reg;
   assign pslverr = pslverr_reg;
   assign reg_wr  = reg_wr_reg;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench for apb_regbank_slave: a small register model predicts each
// transfer's response, which is queued and compared when pready arrives.
module tb_apb_regbank_slave;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cycles;
   } exp_t;

   logic         pclk = 1'b0;
   logic         presetn;
   logic [31:0]  paddr;
   logic [2:0]   pprot;
   logic         psel, penable, pwrite;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;
   logic         pready;
   logic [31:0]  prdata;
   logic         pslverr;
   logic [255:0] hw_status;
   logic [255:0] reg_q;
   logic [7:0]   reg_wr;

   int           total = 0;
   int           bad   = 0;
   exp_t         sb_q[$];
   logic [31:0]  model_regs [8];

   int           pready_cnt = 0;
   int           err_cnt    = 0;
   int           viol_cnt   = 0;
   int           wr_cnt [8];
   logic         prev_pready = 1'b0;

   always #5 pclk = ~pclk;

   apb_regbank_slave #(
      .BASE_ADDR   (32'd8),
      .DATA_WIDTH  (32),
      .N_REGS      (8),
      .WAIT_CYCLES (2),
      .RO_MASK     (8'h80),
      .PRIV_MASK   (8'h40)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .paddr     (paddr),
      .pprot     (pprot),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pready    (pready),
      .prdata    (prdata),
      .pslverr   (pslverr),
      .hw_status (hw_status),
      .reg_q     (reg_q),
      .reg_wr    (reg_wr)
   );

   initial begin
      for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
   end

   always @(negedge pclk) begin
      if (pready === 1'b1) pready_cnt <= pready_cnt + 1;
      if (pready === 1'b1 && pslverr === 1'b1) err_cnt <= err_cnt + 1;
      if (pready !== 1'b1 && (prdata !== 32'd0 || pslverr !== 1'b0)) viol_cnt <= viol_cnt + 1;
      if (pready === 1'b1 && prev_pready === 1'b1) viol_cnt <= viol_cnt + 1;
      prev_pready <= pready;
      for (int i = 0; i < 8; i++) begin
         if (reg_wr[i] === 1'b1) wr_cnt[i] <= wr_cnt[i] + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model_xfer(input logic [31:0] addr, input logic wr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       input logic [2:0] prot);
      exp_t e;
      int   idx;
      e.rdata  = 32'd0;
      e.err    = 1'b0;
      e.cycles = 4;
      if (addr < 32'd8 || addr >= 32'd40 || addr[1:0] != 2'b00) begin
         e.err = 1'b1;
      end else begin
         idx = int'((addr - 32'd8) >> 2);
         if (wr && idx == 7) begin
            e.err = 1'b1;
         end else if (idx == 6 && !prot[0]) begin
            e.err = 1'b1;
         end else if (wr) begin
            for (int b = 0; b < 4; b++) begin
               if (strb[b]) model_regs[idx][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            e.rdata = (idx == 7) ? hw_status[7*32 +: 32] : model_regs[idx];
         end
      end
      return e;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pclk); #1;
         psel    = 1'b0;
         penable = 1'b0;
      end
   endtask

   // Returns during the ACCESS cycle with psel/penable still high.
   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot,
                           output logic [31:0] rd, output logic er, output int cy);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
      pwdata = wdata; pstrb = strb; pprot = prot;
      cy = 1;
      @(posedge pclk); #1;
      penable = 1'b1;
      cy = 2;
      rd = 32'hx;
      er = 1'bx;
      while (pready !== 1'b1 && cy < 30) begin
         @(posedge pclk); #1;
         cy++;
      end
      if (pready === 1'b1) begin
         rd = prdata;
         er = pslverr;
      end else begin
         cy = -1;
      end
      $display("xfer addr=%h wr=%b wdata=%h strb=%b prot=%b rdata=%h err=%b cycles=%0d",
               addr, wr, wdata, strb, prot, rd, er, cy);
   endtask

   task automatic test_reset();
      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'd0; pwdata = 32'd0; pstrb = 4'h0; pprot = 3'b000;
      for (int i = 0; i < 7; i++) hw_status[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
      hw_status[7*32 +: 32] = 32'h0000_7777;
      for (int i = 0; i < 8; i++) model_regs[i] = 32'd0;
      repeat (3) @(posedge pclk);
      #1;
      presetn = 1'b1;
      @(posedge pclk); #1;
      total++;
      if (pready !== 1'b0 || pslverr !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl pready=%b pslverr=%b want 0 0", pready, pslverr);
      end
      total++;
      if (prdata !== 32'd0 || reg_wr !== 8'd0) begin
         bad++; $display("FAIL reset_data prdata=%h reg_wr=%b want 0", prdata, reg_wr);
      end
      total++;
      if (reg_q !== 256'd0) begin
         bad++; $display("FAIL reset_regs reg_q=%h want 0", reg_q);
      end
   endtask

   task automatic test_write_all();
      logic [31:0] rd, a;
      logic        er, w;
      int          cy;
      exp_t        e;
      for (int i = 0; i < 16; i++) begin
         w = (i < 8);
         a = 32'd8 + 32'(4 * (i % 8));
         sb_q.push_back(model_xfer(a, w, 32'(i % 8), 4'hF, 3'b001));
         apb_xfer(a, w, 32'(i % 8), 4'hF, 3'b001, rd, er, cy);
         e = sb_q.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || cy != e.cycles) begin
            bad++;
            $display("FAIL write_all addr=%h wr=%b rdata=%h/%h err=%b/%b cycles=%0d/%0d",
                     a, w, rd, e.rdata, er, e.err, cy, e.cycles);
         end
      end
      idle(1);
   endtask

   task automatic test_strobe();
      logic [31:0] rd;
      logic        er;
      int          cy, w0;
      exp_t        e;
      sb_q.push_back(model_xfer(32'd8, 1'b1, 32'hAABBCCDD, 4'hF, 3'b001));
      apb_xfer(32'd8, 1'b1, 32'hAABBCCDD, 4'hF, 3'b001, rd, er, cy);
      e = sb_q.pop_front();
      total++;
      if (er !== e.err || cy != e.cycles) begin
         bad++; $display("FAIL strobe_full err=%b/%b cycles=%0d/%0d", er, e.err, cy, e.cycles);
      end
      total++;
      if (reg_wr !== 8'h00 || reg_q[31:0] !== 32'd0) begin
         bad++; $display("FAIL commit_early reg_wr=%b reg_q0=%h want 0 0", reg_wr, reg_q[31:0]);
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      total++;
      if (reg_wr !== 8'h01 || reg_q[31:0] !== 32'hAABBCCDD) begin
         bad++; $display("FAIL commit_cycle reg_wr=%b reg_q0=%h want 00000001 aabbccdd",
                         reg_wr, reg_q[31:0]);
      end
      @(posedge pclk); #1;
      total++;
      if (reg_wr !== 8'h00) begin
         bad++; $display("FAIL reg_wr_pulse reg_wr=%b want 0", reg_wr);
      end
      w0 = wr_cnt[0];
      sb_q.push_back(model_xfer(32'd8, 1'b1, 32'h11223344, 4'b0101, 3'b001));
      apb_xfer(32'd8, 1'b1, 32'h11223344, 4'b0101, 3'b001, rd, er, cy);
      void'(sb_q.pop_front());
      sb_q.push_back(model_xfer(32'd8, 1'b1, 32'hFFFFFFFF, 4'b0000, 3'b001));
      apb_xfer(32'd8, 1'b1, 32'hFFFFFFFF, 4'b0000, 3'b001, rd, er, cy);
      e = sb_q.pop_front();
      total++;
      if (er !== e.err || cy != e.cycles) begin
         bad++; $display("FAIL strobe_zero err=%b/%b cycles=%0d/%0d", er, e.err, cy, e.cycles);
      end
      sb_q.push_back(model_xfer(32'd8, 1'b0, 32'd0, 4'hF, 3'b001));
      apb_xfer(32'd8, 1'b0, 32'd0, 4'hF, 3'b001, rd, er, cy);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || rd !== 32'hAA22CC44 || er !== e.err) begin
         bad++; $display("FAIL strobe_merge rdata=%h want %h err=%b", rd, e.rdata, er);
      end
      idle(1);
      total++;
      if (wr_cnt[0] - w0 != 2) begin
         bad++; $display("FAIL strobe_pulses count=%0d want 2", wr_cnt[0] - w0);
      end
   endtask

   task automatic test_ro();
      logic [31:0] rd;
      logic        er, w;
      int          cy;
      exp_t        e;
      hw_status[7*32 +: 32] = 32'hCAFE0001;
      for (int i = 0; i < 4; i++) begin
         w = (i == 1);
         if (i == 3) hw_status[7*32 +: 32] = 32'h0BEE_F00D;
         sb_q.push_back(model_xfer(32'd36, w, 32'h5, 4'hF, 3'b001));
         apb_xfer(32'd36, w, 32'h5, 4'hF, 3'b001, rd, er, cy);
         e = sb_q.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || cy != e.cycles) begin
            bad++;
            $display("FAIL ro_%0d wr=%b rdata=%h/%h err=%b/%b cycles=%0d/%0d",
                     i, w, rd, e.rdata, er, e.err, cy, e.cycles);
         end
      end
      idle(1);
      total++;
      if (reg_q[7*32 +: 32] !== 32'd0) begin
         bad++; $display("FAIL ro_reg_q slice7=%h want 0", reg_q[7*32 +: 32]);
      end
   endtask

   task automatic test_priv();
      logic [31:0] rd;
      logic        er;
      int          cy, w0;
      exp_t        e;
      logic [2:0]  prots [4];
      logic        wrs   [4];
      prots[0] = 3'b000; wrs[0] = 1'b1;
      prots[1] = 3'b110; wrs[1] = 1'b0;
      prots[2] = 3'b001; wrs[2] = 1'b1;
      prots[3] = 3'b001; wrs[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w0 = wr_cnt[6];
         sb_q.push_back(model_xfer(32'd32, wrs[i], 32'h0000_0066, 4'hF, prots[i]));
         apb_xfer(32'd32, wrs[i], 32'h0000_0066, 4'hF, prots[i], rd, er, cy);
         e = sb_q.pop_front();
         idle(2);
         total++;
         if (rd !== e.rdata || er !== e.err || cy != e.cycles) begin
            bad++;
            $display("FAIL priv_%0d rdata=%h/%h err=%b/%b cycles=%0d/%0d",
                     i, rd, e.rdata, er, e.err, cy, e.cycles);
         end
         total++;
         if (wr_cnt[6] - w0 != ((i == 2) ? 1 : 0)) begin
            bad++; $display("FAIL priv_wr_%0d pulses=%0d want %0d", i, wr_cnt[6] - w0,
                            (i == 2) ? 1 : 0);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        er;
      int          cy, e0;
      exp_t        e;
      logic [31:0] addrs [3];
      addrs[0] = 32'd7; addrs[1] = 32'd40; addrs[2] = 32'd10;
      e0 = err_cnt;
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(model_xfer(addrs[i], 1'b0, 32'd0, 4'hF, 3'b001));
         apb_xfer(addrs[i], 1'b0, 32'd0, 4'hF, 3'b001, rd, er, cy);
         e = sb_q.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || cy != e.cycles) begin
            bad++;
            $display("FAIL err_addr addr=%h rdata=%h/%h err=%b/%b cycles=%0d/%0d",
                     addrs[i], rd, e.rdata, er, e.err, cy, e.cycles);
         end
      end
      idle(1);
      total++;
      if (err_cnt - e0 != 3) begin
         bad++; $display("FAIL err_count count=%0d want 3", err_cnt - e0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, a;
      logic        er, w;
      int          cy;
      exp_t        e;
      for (int i = 0; i < 4; i++) begin
         w = (i % 2 == 0);
         a = (i < 2) ? 32'd16 : 32'd28;
         sb_q.push_back(model_xfer(a, w, 32'h1234_5600 | 32'(i), 4'hF, 3'b001));
         apb_xfer(a, w, 32'h1234_5600 | 32'(i), 4'hF, 3'b001, rd, er, cy);
         e = sb_q.pop_front();
         total++;
         if (rd !== e.rdata || er !== e.err || cy != e.cycles) begin
            bad++;
            $display("FAIL b2b_%0d addr=%h rdata=%h/%h err=%b/%b cycles=%0d/%0d",
                     i, a, rd, e.rdata, er, e.err, cy, e.cycles);
         end
      end
      idle(1);
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      logic        er;
      int          cy, w0, p0;
      exp_t        e;
      w0 = wr_cnt[1];
      p0 = pready_cnt;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; paddr = 32'd12; pwrite = 1'b1;
      pwdata = 32'hDEADBEEF; pstrb = 4'hF; pprot = 3'b001;
      @(posedge pclk); #1;
      psel = 1'b0;
      idle(5);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      penable = 1'b0;
      idle(6);
      total++;
      if (pready_cnt != p0 || wr_cnt[1] != w0) begin
         bad++; $display("FAIL abort_resp pready_pulses=%0d reg_wr1=%0d want 0 0",
                         pready_cnt - p0, wr_cnt[1] - w0);
      end
      total++;
      if (reg_q[63:32] !== model_regs[1]) begin
         bad++; $display("FAIL abort_data reg1=%h want %h", reg_q[63:32], model_regs[1]);
      end
      sb_q.push_back(model_xfer(32'd12, 1'b0, 32'd0, 4'hF, 3'b001));
      apb_xfer(32'd12, 1'b0, 32'd0, 4'hF, 3'b001, rd, er, cy);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err || cy != e.cycles) begin
         bad++; $display("FAIL abort_read rdata=%h/%h err=%b/%b", rd, e.rdata, er, e.err);
      end
      idle(1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        er;
      int          cy, w0, p0;
      exp_t        e;
      w0 = wr_cnt[1];
      p0 = pready_cnt;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; paddr = 32'd12; pwrite = 1'b1;
      pwdata = 32'hFEEDFACE; pstrb = 4'hF; pprot = 3'b001;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      presetn = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b1;
      for (int i = 0; i < 8; i++) model_regs[i] = 32'd0;
      repeat (6) begin
         @(posedge pclk); #1;
      end
      psel = 1'b0; penable = 1'b0;
      idle(1);
      total++;
      if (pready_cnt != p0 || wr_cnt[1] != w0) begin
         bad++; $display("FAIL rstmid_resp pready_pulses=%0d reg_wr1=%0d want 0 0",
                         pready_cnt - p0, wr_cnt[1] - w0);
      end
      total++;
      if (reg_q !== 256'd0) begin
         bad++; $display("FAIL rstmid_regs reg_q=%h want 0", reg_q);
      end
      sb_q.push_back(model_xfer(32'd12, 1'b0, 32'd0, 4'hF, 3'b001));
      apb_xfer(32'd12, 1'b0, 32'd0, 4'hF, 3'b001, rd, er, cy);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || er !== e.err || cy != e.cycles) begin
         bad++; $display("FAIL rstmid_read rdata=%h/%h err=%b/%b cycles=%0d/%0d",
                         rd, e.rdata, er, e.err, cy, e.cycles);
      end
      idle(2);
   endtask

   task automatic test_output_gating();
      total++;
      if (viol_cnt != 0) begin
         bad++; $display("FAIL output_gating violations=%0d want 0", viol_cnt);
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_left entries=%0d want 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_all();
      test_strobe();
      test_ro();
      test_priv();
      test_errors();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_output_gating();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
